// File: rtl/ddr5_mc_pwrgd_sequencer.sv
// Per-CPU DDR5 power-good sequencer: staggers channel ADR enables, watches for all-OK, drives CPU DRAMPWRGD.
// All outputs registered (one-cycle response to inputs); a latched fault is sticky until iRst_n.
module ddr5_mc_pwrgd_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int STAGGER_CYC = 8,
  parameter int TIMEOUT_CYC = 100,
  localparam int IDW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPWRGD_PS_PWROK,
  input  logic [NUM_CH-1:0] iCH_PRSNT,
  input  logic [NUM_CH-1:0] iCH_DRAMPWRGD_OK,
  input  logic [NUM_CH-1:0] iCH_MEM_FLT,
  output logic [NUM_CH-1:0] oCH_ADR_EN,
  output logic              oDRAMPWRGD_CPU,
  output logic              oMEM_FLT,
  output logic              oTIMEOUT_FLT,
  output logic [IDW-1:0]    oFLT_CH_ID,
  output logic [2:0]        oSTATE
);

  localparam int MAXC = (STAGGER_CYC > TIMEOUT_CYC) ? STAGGER_CYC : TIMEOUT_CYC;
  localparam int CNTW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT_OK = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [CNTW-1:0]   r_cnt, w_nxt_cnt;
  logic [IDW-1:0]    r_idx, w_nxt_idx;
  logic [NUM_CH-1:0] r_adr_en, w_nxt_adr_en;
  logic              r_pwrgd, w_nxt_pwrgd;
  logic              r_mem_flt, w_nxt_mem_flt;
  logic              r_to_flt, w_nxt_to_flt;
  logic [IDW-1:0]    r_flt_id, w_nxt_flt_id;

  logic              w_allok;
  logic [NUM_CH-1:0] w_flt_vec, w_drop_vec;
  logic              w_go_idle, w_go_flt, w_set_to;
  logic [IDW-1:0]    w_flt_id;

  function automatic logic [IDW-1:0] f_lowest(input logic [NUM_CH-1:0] v);
    f_lowest = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (v[k]) f_lowest = IDW'(k);
  endfunction

  assign w_allok    = &(iCH_DRAMPWRGD_OK | ~iCH_PRSNT);
  assign w_flt_vec  = iCH_MEM_FLT & iCH_PRSNT;
  assign w_drop_vec = ~iCH_DRAMPWRGD_OK & iCH_PRSNT;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_idx     = r_idx;
    w_nxt_adr_en  = r_adr_en;
    w_nxt_pwrgd   = r_pwrgd;
    w_nxt_mem_flt = r_mem_flt;
    w_nxt_to_flt  = r_to_flt;
    w_nxt_flt_id  = r_flt_id;
    w_go_idle     = 1'b0;
    w_go_flt      = 1'b0;
    w_set_to      = 1'b0;
    w_flt_id      = '0;

    case (r_state)
      ST_IDLE: begin
        if (iPWRGD_PS_PWROK) begin
          w_nxt_state = ST_RELEASE;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
        end
      end
      ST_RELEASE: begin
        if (!iPWRGD_PS_PWROK) begin
          w_go_idle = 1'b1;
        end else if (|w_flt_vec) begin
          w_go_flt = 1'b1;
          w_flt_id = f_lowest(w_flt_vec);
        end else if (r_cnt == CNTW'(STAGGER_CYC - 1)) begin
          w_nxt_cnt = '0;
          for (int k = 0; k < NUM_CH; k++)
            if (IDW'(k) == r_idx) w_nxt_adr_en[k] = 1'b1;
          if (r_idx == IDW'(NUM_CH - 1)) begin
            w_nxt_state = ST_WAIT_OK;
            w_nxt_idx   = '0;
          end else begin
            w_nxt_idx = r_idx + 1'b1;
          end
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_OK: begin
        // allok is tested before the watchdog so a same-cycle OK beats the timeout
        if (!iPWRGD_PS_PWROK) begin
          w_go_idle = 1'b1;
        end else if (|w_flt_vec) begin
          w_go_flt = 1'b1;
          w_flt_id = f_lowest(w_flt_vec);
        end else if (w_allok) begin
          w_nxt_state = ST_RUN;
          w_nxt_pwrgd = 1'b1;
          w_nxt_cnt   = '0;
        end else if (r_cnt == CNTW'(TIMEOUT_CYC - 1)) begin
          w_go_flt = 1'b1;
          w_set_to = 1'b1;
          w_flt_id = f_lowest(w_drop_vec);
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!iPWRGD_PS_PWROK) begin
          w_go_idle = 1'b1;
        end else if (|(w_flt_vec | w_drop_vec)) begin
          w_go_flt = 1'b1;
          w_flt_id = f_lowest(w_flt_vec | w_drop_vec);
        end
      end
      ST_FAULT: begin
        w_nxt_state = ST_FAULT;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_go_idle) begin
      w_nxt_state  = ST_IDLE;
      w_nxt_adr_en = '0;
      w_nxt_pwrgd  = 1'b0;
      w_nxt_cnt    = '0;
      w_nxt_idx    = '0;
    end else if (w_go_flt) begin
      w_nxt_state   = ST_FAULT;
      w_nxt_adr_en  = '0;
      w_nxt_pwrgd   = 1'b0;
      w_nxt_mem_flt = 1'b1;
      w_nxt_to_flt  = w_set_to;
      w_nxt_flt_id  = w_flt_id;
      w_nxt_cnt     = '0;
      w_nxt_idx     = '0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_adr_en  <= '0;
      r_pwrgd   <= 1'b0;
      r_mem_flt <= 1'b0;
      r_to_flt  <= 1'b0;
      r_flt_id  <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_idx     <= w_nxt_idx;
      r_adr_en  <= w_nxt_adr_en;
      r_pwrgd   <= w_nxt_pwrgd;
      r_mem_flt <= w_nxt_mem_flt;
      r_to_flt  <= w_nxt_to_flt;
      r_flt_id  <= w_nxt_flt_id;
    end
  end

  assign oCH_ADR_EN     = r_adr_en;
  assign oDRAMPWRGD_CPU = r_pwrgd;
  assign oMEM_FLT       = r_mem_flt;
  assign oTIMEOUT_FLT   = r_to_flt;
  assign oFLT_CH_ID     = r_flt_id;
  assign oSTATE         = r_state;

endmodule
